cam_frame_capture_ctrl: RTL
===========================

// Module: cam_frame_capture_ctrl
// PURPOSE
//   Frame-capture sequencer between the CameraLink AXIS receiver and downstream video IP.
//   Software arms a capture of N frames (or continuous); the block discards beats until a
//   start-of-frame (tuser), forwards whole frames only, and stops cleanly on frame boundaries.
//   Checks every frame against the programmed geometry and reports counts and errors.
// PARAMETERS
//   DATA_WIDTH   24  pixel bus width (port C:B:A)
//   USER_WIDTH   1   tuser width; bit 0 = start of frame
//   CNT_WIDTH    16  pixel/line counter and geometry width
//   FRM_WIDTH    8   frame request/count width
// PORTS
//   axis_clk        in   1           single clock, all logic
//   rst             in   1           synchronous reset, active-high
//   s_axis_tdata    in   DATA_WIDTH  pixel from receiver
//   s_axis_tvalid   in   1
//   s_axis_tready   out  1
//   s_axis_tlast    in   1           end of line
//   s_axis_tuser    in   USER_WIDTH  [0]=start of frame
//   m_axis_tdata    out  DATA_WIDTH  registered copy of accepted beat
//   m_axis_tvalid   out  1
//   m_axis_tready   in   1
//   m_axis_tlast    out  1
//   m_axis_tuser    out  USER_WIDTH
//   cfg_start       in   1           1-cycle pulse: arm capture
//   cfg_stop        in   1           1-cycle pulse: stop at next frame boundary
//   cfg_nframes     in   FRM_WIDTH   frames to capture; 0 = continuous; sampled on cfg_start
//   cfg_width       in   CNT_WIDTH   expected pixels/line (>=1); sampled on cfg_start
//   cfg_height      in   CNT_WIDTH   expected lines/frame (>=1); sampled on cfg_start
//   err_clr         in   1           clears err_* sticky flags
//   busy            out  1           state != IDLE
//   frame_done      out  1           1-cycle pulse per completed, correctly-sized frame
//   frames_captured out  FRM_WIDTH   completed frames since cfg_start, wraps
//   err_width       out  1           sticky: line length != cfg_width
//   err_height      out  1           sticky: frame cut short by early SOF
// BEHAVIOUR
//   Reset: state IDLE; m_axis_tvalid/tlast/tuser, busy, frame_done, errs, counters = 0.
//   Output stage: one register; s_axis_tready = ~m_axis_tvalid | m_axis_tready in CAPTURE;
//     s_axis_tready = 1 in IDLE/WAIT_SOF (discard). Forward latency 1 cycle; holds data
//     stable while m_axis_tvalid & ~m_axis_tready. "Accept" = s_axis_tvalid & s_axis_tready.
//   States:
//     IDLE     : discard beats. cfg_start -> latch cfg_*, frames_captured<=0, -> WAIT_SOF.
//     WAIT_SOF : discard until accepted beat with tuser[0]=1 while tready computed as CAPTURE;
//                that beat is forwarded, pix<=1, line<=0, -> CAPTURE. cfg_stop -> IDLE now.
//     CAPTURE  : forward every accepted beat. pix++ per beat (saturate); on tlast beat:
//                pix!=width -> err_width<=1; pix<=0; line++. When line reaches height on
//                tlast: frame_done pulse, frames_captured++; then IDLE if stop pending or
//                frames_captured+1==nframes (nframes!=0), else WAIT_SOF.
//   Early SOF in CAPTURE (tuser beat with pix!=0 or line!=0): err_height<=1, frame not counted,
//     beat forwarded as first pixel of new frame, counters restart (pix<=1, line<=0).
//   Line longer than width without tlast: keep counting, flag at tlast only.
//   cfg_stop in CAPTURE sets stop pending; cleared on entry to IDLE. cfg_start outside IDLE
//     ignored. cfg_start & cfg_stop same cycle in IDLE: start wins, stop ignored.
//   Entering IDLE with m_axis_tvalid=1: the pending beat still drains to m_axis.
//   err_clr and a new error same cycle: error wins. rst mid-frame: immediate IDLE, output
//     beat dropped, tvalid=0 next cycle.
// TESTING
//   nframes=2,width=4,height=3, 4 frames streamed, tready=1 -> frames 2,3 discarded,
//     frame_done x2, frames_captured=2, 24 beats out, busy falls after last tlast.
//   Start mid-frame -> partial frame discarded, output begins with tuser=1 beat.
//   Random m_axis_tready backpressure -> output sequence bit-identical, no drop/dup.
//   Line of 3 pixels with width=4 -> err_width=1, frame still counted; err_clr -> 0.
//   SOF after 2 of 3 lines -> err_height=1, frame_done absent, next frame counted.
//   nframes=0, cfg_stop mid-frame 1 -> frame 1 completes, then IDLE, frames_captured=1.

Source files
------------

// File: rtl/cam_frame_capture_ctrl.sv
`default_nettype none
// ============================================================================
// cam_frame_capture_ctrl: frame-gated AXIS capture sequencer with geometry checks
// Rev 1.0
// ============================================================================
module cam_frame_capture_ctrl #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned FRM_WIDTH  = 8
) (
  input  logic                  axis_clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [FRM_WIDTH-1:0]  cfg_nframes,
  input  logic [CNT_WIDTH-1:0]  cfg_width,
  input  logic [CNT_WIDTH-1:0]  cfg_height,
  input  logic                  err_clr,
  output logic                  busy,
  output logic                  frame_done,
  output logic [FRM_WIDTH-1:0]  frames_captured,
  output logic                  err_width,
  output logic                  err_height
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOF = 2'd1,
    S_CAPTURE  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [FRM_WIDTH-1:0]  nframes_q, nframes_d;
  logic [CNT_WIDTH-1:0]  width_q, width_d;
  logic [CNT_WIDTH-1:0]  height_q, height_d;
  logic [CNT_WIDTH-1:0]  pix_q, pix_d;
  logic [CNT_WIDTH-1:0]  line_q, line_d;
  logic                  stop_q, stop_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic [USER_WIDTH-1:0] tuser_q, tuser_d;
  logic                  done_q, done_d;
  logic [FRM_WIDTH-1:0]  frames_q, frames_d;
  logic                  errw_q, errw_d;
  logic                  errh_q, errh_d;

  logic                  out_free;
  logic                  sof;
  logic                  accept;
  logic                  fwd;
  logic                  early_sof;
  logic                  line_end;
  logic                  frame_end;
  logic                  last_frame;
  logic [CNT_WIDTH-1:0]  pix_base, line_base, pix_inc, line_inc;

  assign out_free = ~tvalid_q | m_axis_tready;
  assign sof      = s_axis_tuser[0];

  // Non-SOF beats are always swallowed outside CAPTURE; an SOF beat that will
  // be forwarded must wait for room in the output register.
  always_comb begin
    s_axis_tready = 1'b1;
    if (state_q == S_CAPTURE) begin
      s_axis_tready = out_free;
    end else if (state_q == S_WAIT_SOF && sof) begin
      s_axis_tready = out_free;
    end
  end

  assign accept    = s_axis_tvalid & s_axis_tready;
  assign fwd       = accept & ((state_q == S_CAPTURE) |
                               ((state_q == S_WAIT_SOF) & sof & ~cfg_stop));
  assign early_sof = fwd & sof & (state_q == S_CAPTURE) &
                     ((pix_q != '0) | (line_q != '0));

  // An SOF beat restarts geometry counting as pixel one of line zero.
  assign pix_base   = (fwd & sof) ? '0 : pix_q;
  assign line_base  = (fwd & sof) ? '0 : line_q;
  assign pix_inc    = (&pix_base) ? pix_base : pix_base + CNT_WIDTH'(1);
  assign line_inc   = line_base + CNT_WIDTH'(1);
  assign line_end   = fwd & s_axis_tlast;
  assign frame_end  = line_end & (line_inc == height_q);
  assign last_frame = (nframes_q != '0) && ((frames_q + FRM_WIDTH'(1)) == nframes_q);

  always_comb begin
    state_d   = state_q;
    nframes_d = nframes_q;
    width_d   = width_q;
    height_d  = height_q;
    pix_d     = pix_q;
    line_d    = line_q;
    stop_d    = stop_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tuser_d   = tuser_q;
    done_d    = 1'b0;
    frames_d  = frames_q;
    errw_d    = errw_q;
    errh_d    = errh_q;

    if (fwd) begin
      tvalid_d = 1'b1;
      tdata_d  = s_axis_tdata;
      tlast_d  = s_axis_tlast;
      tuser_d  = s_axis_tuser;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    if (fwd) begin
      pix_d  = line_end ? '0 : pix_inc;
      line_d = line_end ? line_inc : line_base;
    end

    if (err_clr) begin
      errw_d = 1'b0;
      errh_d = 1'b0;
    end
    if (line_end && (pix_inc != width_q)) begin
      errw_d = 1'b1;
    end
    if (early_sof) begin
      errh_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (cfg_start) begin
          nframes_d = cfg_nframes;
          width_d   = cfg_width;
          height_d  = cfg_height;
          frames_d  = '0;
          state_d   = S_WAIT_SOF;
        end
      end
      S_WAIT_SOF: begin
        if (cfg_stop) begin
          state_d = S_IDLE;
          stop_d  = 1'b0;
        end else if (fwd) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (cfg_stop) begin
          stop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame completion can occur on the SOF beat itself for 1x1 geometry.
    if (frame_end) begin
      done_d   = 1'b1;
      frames_d = frames_q + FRM_WIDTH'(1);
      if (stop_q || cfg_stop || last_frame) begin
        state_d = S_IDLE;
        stop_d  = 1'b0;
      end else begin
        state_d = S_WAIT_SOF;
      end
    end
  end

  always_ff @(posedge axis_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      nframes_q <= '0;
      width_q   <= '0;
      height_q  <= '0;
      pix_q     <= '0;
      line_q    <= '0;
      stop_q    <= 1'b0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= '0;
      done_q    <= 1'b0;
      frames_q  <= '0;
      errw_q    <= 1'b0;
      errh_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      nframes_q <= nframes_d;
      width_q   <= width_d;
      height_q  <= height_d;
      pix_q     <= pix_d;
      line_q    <= line_d;
      stop_q    <= stop_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
      done_q    <= done_d;
      frames_q  <= frames_d;
      errw_q    <= errw_d;
      errh_q    <= errh_d;
    end
  end

  assign m_axis_tdata    = tdata_q;
  assign m_axis_tvalid   = tvalid_q;
  assign m_axis_tlast    = tlast_q;
  assign m_axis_tuser    = tuser_q;
  assign busy            = (state_q != S_IDLE);
  assign frame_done      = done_q;
  assign frames_captured = frames_q;
  assign err_width       = errw_q;
  assign err_height      = errh_q;

endmodule
`default_nettype wire
